// File: rtl/day10_parser_if.sv
// AXI-Stream byte channel feeding the day10 line parser.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/day10_parser.sv
// ASCII machine-line parser for the day10 solver: one packed record per line.
// Define DAY10_PARSER_CHECK_EN to add the sticky malformed-input flag `err`.
module day10_parser #(
    parameter int MAX_NUM_LIGHTS  = 7,
    parameter int MAX_NUM_BUTTONS = 7,
    parameter int AXI_DATA_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst_n,
    axi_stream_if.slave data_in,
    output logic rec_valid,
    input  logic rec_ready,
    output logic [MAX_NUM_LIGHTS-1:0] rec_lights,
    output logic [$clog2(MAX_NUM_LIGHTS+1)-1:0] rec_num_lights,
    output logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] rec_buttons,
    output logic [$clog2(MAX_NUM_BUTTONS+1)-1:0] rec_num_buttons,
    output logic rec_last
`ifdef DAY10_PARSER_CHECK_EN
    ,
    output logic err
`endif
);
    localparam int ML  = MAX_NUM_LIGHTS;
    localparam int MB  = MAX_NUM_BUTTONS;
    localparam int NLW = $clog2(ML + 1);
    localparam int NBW = $clog2(MB + 1);
    localparam int BW  = MB * ML;

    localparam logic [NLW-1:0] ML_C = NLW'(ML);
    localparam logic [NBW-1:0] MB_C = NBW'(MB);

    localparam logic [7:0] CH_LB   = 8'h5B;
    localparam logic [7:0] CH_RB   = 8'h5D;
    localparam logic [7:0] CH_DOT  = 8'h2E;
    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_LP   = 8'h28;
    localparam logic [7:0] CH_RP   = 8'h29;
    localparam logic [7:0] CH_COM  = 8'h2C;
    localparam logic [7:0] CH_LC   = 8'h7B;
    localparam logic [7:0] CH_NL   = 8'h0A;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_CR   = 8'h0D;

    localparam logic [2:0] S_SEEK   = 3'd0;
    localparam logic [2:0] S_LIGHTS = 3'd1;
    localparam logic [2:0] S_GROUPS = 3'd2;
    localparam logic [2:0] S_BUTTON = 3'd3;
    localparam logic [2:0] S_JOLT   = 3'd4;
    localparam logic [2:0] S_EMIT   = 3'd5;

    logic [2:0]     state_q, state_d;
    logic [ML-1:0]  lights_q, lights_d;
    logic [NLW-1:0] nl_q, nl_d;
    logic [BW-1:0]  btn_q, btn_d;
    logic [NBW-1:0] nb_q, nb_d;
    logic [ML-1:0]  cur_q, cur_d;
    logic           last_q, last_d;

    logic [AXI_DATA_WIDTH-1:0] beat;
    logic [7:0] b;
    logic [3:0] dig;
    logic       fire;
    logic       skip;
    logic       is_dig;

    assign beat   = data_in.tdata;
    assign b      = beat[7:0];
    assign dig    = b[3:0];
    assign is_dig = (b >= 8'h30) && (b <= 8'h39);
    assign skip   = (b == CH_SP) || (b == CH_CR);

    // Input is frozen for as long as a record is waiting downstream.
    assign rec_valid      = (state_q == S_EMIT);
    assign data_in.tready = !rec_valid;
    assign fire           = data_in.tvalid && !rec_valid;

    always_comb begin
        state_d  = state_q;
        lights_d = lights_q;
        nl_d     = nl_q;
        btn_d    = btn_q;
        nb_d     = nb_q;
        cur_d    = cur_q;
        last_d   = last_q;
        if (state_q == S_EMIT) begin
            if (rec_ready) begin
                state_d  = S_SEEK;
                lights_d = '0;
                nl_d     = '0;
                btn_d    = '0;
                nb_d     = '0;
                cur_d    = '0;
                last_d   = 1'b0;
            end
        end else if (fire) begin
            if (!skip) begin
                unique case (state_q)
                    S_SEEK: begin
                        if (b == CH_LB) state_d = S_LIGHTS;
                    end
                    S_LIGHTS: begin
                        unique case (1'b1)
                            (b == CH_DOT) || (b == CH_HASH): begin
                                if (nl_q < ML_C) begin
                                    for (int i = 0; i < ML; i++) begin
                                        if (nl_q == NLW'(i))
                                            lights_d[i] = (b == CH_HASH);
                                    end
                                    nl_d = nl_q + NLW'(1);
                                end
                            end
                            b == CH_RB: state_d = S_GROUPS;
                            default: ;
                        endcase
                    end
                    S_GROUPS: begin
                        unique case (1'b1)
                            b == CH_LP: begin
                                cur_d   = '0;
                                state_d = S_BUTTON;
                            end
                            b == CH_LC: state_d = S_JOLT;
                            b == CH_NL: state_d = S_EMIT;
                            default: ;
                        endcase
                    end
                    S_BUTTON: begin
                        unique case (1'b1)
                            is_dig: begin
                                for (int i = 0; i < ML; i++) begin
                                    if (dig == 4'(i)) cur_d[i] = 1'b1;
                                end
                            end
                            b == CH_RP: begin
                                // Groups past capacity are consumed but not kept.
                                for (int j = 0; j < MB; j++) begin
                                    if (nb_q == NBW'(j))
                                        btn_d[j*ML +: ML] = cur_q;
                                end
                                if (nb_q < MB_C) nb_d = nb_q + NBW'(1);
                                state_d = S_GROUPS;
                            end
                            default: ;
                        endcase
                    end
                    S_JOLT: begin
                        if (b == CH_NL) state_d = S_EMIT;
                    end
                    default: state_d = S_SEEK;
                endcase
            end
            if (data_in.tlast) state_d = S_EMIT;
            if (state_d == S_EMIT) last_d = data_in.tlast;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_SEEK;
            lights_q <= '0;
            nl_q     <= '0;
            btn_q    <= '0;
            nb_q     <= '0;
            cur_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lights_q <= lights_d;
            nl_q     <= nl_d;
            btn_q    <= btn_d;
            nb_q     <= nb_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
        end
    end

    assign rec_lights      = lights_q;
    assign rec_num_lights  = nl_q;
    assign rec_buttons     = btn_q;
    assign rec_num_buttons = nb_q;
    assign rec_last        = last_q;

`ifdef DAY10_PARSER_CHECK_EN
    logic bad;
    logic err_q;

    always_comb begin
        bad = 1'b0;
        if (fire && !skip) begin
            unique case (state_q)
                S_SEEK:
                    bad = (b != CH_LB) && (b != CH_NL);
                S_LIGHTS:
                    if ((b == CH_DOT) || (b == CH_HASH))
                        bad = (nl_q == ML_C);
                    else
                        bad = (b != CH_RB);
                S_GROUPS:
                    bad = (b != CH_LP) && (b != CH_LC) && (b != CH_NL);
                S_BUTTON:
                    if (is_dig)
                        bad = (dig >= 4'(ML));
                    else if (b == CH_RP)
                        bad = (nb_q == MB_C);
                    else
                        bad = (b != CH_COM);
                default: bad = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_q | bad;
    end

    assign err = err_q;
`endif
endmodule

// File: tb/tb_day10_parser.sv
// Randomized self-checking bench for day10_parser with a line-level model.
module tb_day10_parser;
    localparam int ML = 7;
    localparam int MB = 7;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [ML-1:0]    lights;
        int               nl;
        logic [MB*ML-1:0] btn;
        int               nb;
        bit               last;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi_stream_if #(.DATA_WIDTH(8)) s_if ();

    logic             rec_valid;
    logic             rec_ready;
    logic [ML-1:0]    rec_lights;
    logic [2:0]       rec_num_lights;
    logic [MB*ML-1:0] rec_buttons;
    logic [2:0]       rec_num_buttons;
    logic             rec_last;
`ifdef DAY10_PARSER_CHECK_EN
    logic             err;
`endif

    day10_parser #(
        .MAX_NUM_LIGHTS (ML),
        .MAX_NUM_BUTTONS(MB),
        .AXI_DATA_WIDTH (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (s_if),
        .rec_valid      (rec_valid),
        .rec_ready      (rec_ready),
        .rec_lights     (rec_lights),
        .rec_num_lights (rec_num_lights),
        .rec_buttons    (rec_buttons),
        .rec_num_buttons(rec_num_buttons),
        .rec_last       (rec_last)
`ifdef DAY10_PARSER_CHECK_EN
        ,
        .err            (err)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit exp_err = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic s2q(input string s, output bq_t q);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    task automatic cmp_rec(input rec_t e, input string p);
        chk({p, "_lights"}, rec_lights, e.lights);
        chk({p, "_nl"}, rec_num_lights, e.nl);
        chk({p, "_btn"}, rec_buttons, e.btn);
        chk({p, "_nb"}, rec_num_buttons, e.nb);
        chk({p, "_last"}, rec_last, e.last);
    endtask

    // Called at a negedge with no record pending; returns at a negedge.
    task automatic send(input bq_t q, input bit last_end, input bit gaps);
        int n;
        n = q.size();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                s_if.tvalid = 1'b0;
                @(posedge clk);
                @(negedge clk);
            end
            if (i == n - 1) chk("pre_valid", rec_valid, 1'b0);
            s_if.tvalid = 1'b1;
            s_if.tdata  = q[i];
            s_if.tlast  = last_end && (i == n - 1);
            @(posedge clk);
            @(negedge clk);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic collect(input rec_t e, input int stall);
        chk("valid", rec_valid, 1'b1);
        chk("tready_hold", s_if.tready, 1'b0);
        cmp_rec(e, "rec");
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", rec_valid, 1'b1);
            chk("stall_tready", s_if.tready, 1'b0);
            cmp_rec(e, "stable");
        end
        rec_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rec_ready = 1'b0;
        chk("post_valid", rec_valid, 1'b0);
        chk("post_tready", s_if.tready, 1'b1);
`ifdef DAY10_PARSER_CHECK_EN
        chk("err", err, exp_err);
`endif
    endtask

    task automatic clear_rec(output rec_t e);
        e.lights = '0;
        e.nl     = 0;
        e.btn    = '0;
        e.nb     = 0;
        e.last   = 1'b0;
    endtask

    // Line model: the record follows directly from the drawn line contents.
    task automatic build_random(output bq_t q, output rec_t e);
        int n, g, k, d;
        bit on;
        logic [ML-1:0] m;
        clear_rec(e);
        q = {};
        n = $urandom_range(1, 9);
        q.push_back(8'h5B);
        for (int i = 0; i < n; i++) begin
            on = 1'($urandom_range(1));
            q.push_back(on ? 8'h23 : 8'h2E);
            if (i < ML) e.lights[i] = on;
            if ($urandom_range(5) == 0) q.push_back(8'h20);
        end
        e.nl = (n < ML) ? n : ML;
        if (n > ML) exp_err = 1'b1;
        q.push_back(8'h5D);
        g = $urandom_range(0, 9);
        for (int j = 0; j < g; j++) begin
            q.push_back(8'h20);
            q.push_back(8'h28);
            k = $urandom_range(1, 4);
            m = '0;
            for (int t = 0; t < k; t++) begin
                d = $urandom_range(0, 9);
                if (t > 0) q.push_back(8'h2C);
                q.push_back(8'(8'h30 + d));
                if (d < ML) m[d] = 1'b1;
                else exp_err = 1'b1;
            end
            q.push_back(8'h29);
            if (j < MB) e.btn[j*ML +: ML] = m;
        end
        e.nb = (g < MB) ? g : MB;
        if (g > MB) exp_err = 1'b1;
        if ($urandom_range(1) == 1) begin
            q.push_back(8'h20);
            q.push_back(8'h7B);
            k = $urandom_range(1, 5);
            for (int t = 0; t < k; t++) begin
                if (t > 0) q.push_back(8'h2C);
                q.push_back(8'(8'h30 + $urandom_range(0, 9)));
            end
            q.push_back(8'h7D);
        end
        if ($urandom_range(3) == 0) q.push_back(8'h0D);
        q.push_back(8'h0A);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bq_t  q;
        rec_t e;
        rst_n       = 1'b0;
        rec_ready   = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'h00;
        s_if.tlast  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", rec_valid, 1'b0);
        chk("rst_tready", s_if.tready, 1'b1);
        clear_rec(e);
        cmp_rec(e, "rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Worked example from the puzzle text.
        s2q("[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n", q);
        send(q, 1'b1, 1'b0);
        clear_rec(e);
        e.lights = 7'b0000110;
        e.nl = 4;
        e.nb = 6;
        e.btn[0*ML +: ML] = 7'b0001000;
        e.btn[1*ML +: ML] = 7'b0001010;
        e.btn[2*ML +: ML] = 7'b0000100;
        e.btn[3*ML +: ML] = 7'b0001100;
        e.btn[4*ML +: ML] = 7'b0000101;
        e.btn[5*ML +: ML] = 7'b0000011;
        e.last = 1'b1;
        collect(e, 2);

        // Blank line yields nothing; CR is ignored.
        s2q("\n[#]\r\n", q);
        send(q, 1'b1, 1'b0);
        clear_rec(e);
        e.lights = 7'b0000001;
        e.nl = 1;
        e.last = 1'b1;
        collect(e, 0);

        // tlast on ')' without a newline.
        s2q("[#.] (0,1)", q);
        send(q, 1'b1, 1'b0);
        clear_rec(e);
        e.lights = 7'b0000001;
        e.nl = 2;
        e.nb = 1;
        e.btn[0 +: ML] = 7'b0000011;
        e.last = 1'b1;
        collect(e, 1);

        // tlast before any '[' gives an all-zero record.
        s2q("\n ", q);
        send(q, 1'b1, 1'b0);
        clear_rec(e);
        e.last = 1'b1;
        collect(e, 0);

        // Back-to-back lines with a long stall and the next byte waiting.
        s2q("[#] (0)\n", q);
        send(q, 1'b0, 1'b0);
        clear_rec(e);
        e.lights = 7'b0000001;
        e.nl = 1;
        e.nb = 1;
        e.btn[0 +: ML] = 7'b0000001;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h5B;
        collect(e, 10);
        s2q("[.#] (1) (0,1)\n", q);
        send(q, 1'b1, 1'b0);
        clear_rec(e);
        e.lights = 7'b0000010;
        e.nl = 2;
        e.nb = 2;
        e.btn[0*ML +: ML] = 7'b0000010;
        e.btn[1*ML +: ML] = 7'b0000011;
        e.last = 1'b1;
        collect(e, 0);

        // Light and button overflow saturate.
        s2q("[########] (0) (1) (2) (3) (4) (5) (6) (7)\n", q);
        send(q, 1'b0, 1'b0);
        clear_rec(e);
        e.lights = 7'h7F;
        e.nl = 7;
        e.nb = 7;
        for (int j = 0; j < MB; j++) e.btn[j*ML + j] = 1'b1;
        exp_err = 1'b1;
        collect(e, 0);

        // Reset in the middle of a line drops it.
        s2q("[.#", q);
        send(q, 1'b0, 1'b0);
        rst_n = 1'b0;
        exp_err = 1'b0;
        #1;
        chk("mid_rst_valid", rec_valid, 1'b0);
        chk("mid_rst_tready", s_if.tready, 1'b1);
        clear_rec(e);
        cmp_rec(e, "mid_rst");
`ifdef DAY10_PARSER_CHECK_EN
        chk("mid_rst_err", err, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s2q("[#..#] (1)\n", q);
        send(q, 1'b0, 1'b0);
        clear_rec(e);
        e.lights = 7'b0001001;
        e.nl = 4;
        e.nb = 1;
        e.btn[0 +: ML] = 7'b0000010;
        collect(e, 0);

        // Random lines against the line model.
        for (int r = 0; r < 30; r++) begin
            build_random(q, e);
            e.last = (r == 29);
            send(q, e.last, 1'b1);
            collect(e, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
